fir3_tdm_sched: RTL and testbench

Time-division scheduler that shares one 3-tap FIR datapath among `NCH` ECG input channels. It performs round-robin arbitration between channel sample requests and keeps a per-channel delay line. It sequences the three tap products through an external `W`-bit adder port, so exact or approximate adder variants can be plugged in unchanged. It sits between the sample sources and the result sink of the filter chain.

---
 rtl/fir3_tdm_sched.sv | 157 +++++++++++++++
 tb/tb_fir3_tdm_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir3_tdm_sched.sv
// Time-division 3-tap FIR scheduler: NCH channels share one datapath, arbitrated round-robin.
// The tap products are accumulated through an external W-bit adder port (add_a/add_b -> add_s).
module fir3_tdm_sched #(
  parameter int NCH  = 4,
  parameter int W    = 16,
  parameter int FRAC = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           in_valid,
  input  logic [NCH*W-1:0]         in_data,
  output logic [NCH-1:0]           in_ready,
  input  logic                     coef_we,
  input  logic [1:0]               coef_sel,
  input  logic [W-1:0]             coef_data,
  output logic [W-1:0]             add_a,
  output logic [W-1:0]             add_b,
  input  logic [W-1:0]             add_s,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   out_ch,
  output logic [W-1:0]             out_data,
  output logic                     busy
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [2:0] {StIdle, StTap0, StTap1, StTap2, StOut} state_e;

  state_e         state, state_next;
  logic [CW-1:0]  rr_ptr;
  logic [CW-1:0]  ch;
  logic [W-1:0]   x0;
  logic [W-1:0]   acc;
  logic [W-1:0]   coef [3];
  logic [W-1:0]   h1 [NCH];
  logic [W-1:0]   h2 [NCH];

  logic           grant_any;
  logic [CW-1:0]  grant_idx;
  logic [CW-1:0]  cand;
  logic [CW-1:0]  rr_next;

  // Signed Q-format product: full 2W product, arithmetic shift, keep low W bits (wraps).
  function automatic logic [W-1:0] tap_mul(input logic [W-1:0] a, input logic [W-1:0] c);
    logic signed [2*W-1:0] prod;
    prod = $signed({{W{a[W-1]}}, a}) * $signed({{W{c[W-1]}}, c});
    prod = prod >>> FRAC;
    return prod[W-1:0];
  endfunction

  // Round-robin search: first requester at or after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = CW'((int'(rr_ptr) + k) % NCH);
      if (!grant_any && in_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    rr_next = CW'((int'(grant_idx) + 1) % NCH);
  end

  // Handshake is only offered in IDLE and never while reset is held.
  always_comb begin
    in_ready = '0;
    if (state == StIdle && !rst && grant_any) begin
      in_ready = NCH'(1) << grant_idx;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: fixed five-state sequence per accepted sample.
  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (grant_any) state_next = StTap0;
      StTap0:  state_next = StTap1;
      StTap1:  state_next = StTap2;
      StTap2:  state_next = StOut;
      StOut:   state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // Datapath: coefficient writes, sample capture, accumulation and history shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      ch     <= '0;
      x0     <= '0;
      acc    <= '0;
      for (int i = 0; i < 3; i++) coef[i] <= '0;
      for (int i = 0; i < NCH; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
      end
    end else begin
      unique case (state)
        StIdle: begin
          // Written here so a same-cycle grant sees the new value in TAP0.
          if (coef_we && coef_sel != 2'd3) coef[coef_sel] <= coef_data;
          if (grant_any) begin
            x0     <= in_data[int'(grant_idx)*W +: W];
            ch     <= grant_idx;
            rr_ptr <= rr_next;
          end
        end
        StTap0: acc <= tap_mul(x0, coef[0]);
        StTap1: acc <= add_s;
        StTap2: acc <= add_s;
        StOut: begin
          h2[ch] <= h1[ch];
          h1[ch] <= x0;
        end
        default: ;
      endcase
    end
  end

  // Outputs: adder operands only in TAP1/TAP2, result only in OUT.
  always_comb begin
    add_a     = '0;
    add_b     = '0;
    out_valid = 1'b0;
    out_ch    = '0;
    out_data  = '0;
    busy      = (state != StIdle);
    unique case (state)
      StTap1: begin
        add_a = acc;
        add_b = tap_mul(h1[ch], coef[1]);
      end
      StTap2: begin
        add_a = acc;
        add_b = tap_mul(h2[ch], coef[2]);
      end
      StOut: begin
        out_valid = 1'b1;
        out_ch    = ch;
        out_data  = acc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir3_tdm_sched.sv
// Scoreboard bench for fir3_tdm_sched: a transaction-level model predicts grants and results,
// a separate monitor compares each out_valid against the queued expectation.
module tb_fir3_tdm_sched;

  localparam int NCH  = 4;
  localparam int W    = 16;
  localparam int FRAC = 15;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       in_valid;
  logic [NCH*W-1:0]     in_data;
  logic [NCH-1:0]       in_ready;
  logic                 coef_we;
  logic [1:0]           coef_sel;
  logic [W-1:0]         coef_data;
  logic [W-1:0]         add_a, add_b, add_s;
  logic                 out_valid;
  logic [1:0]           out_ch;
  logic [W-1:0]         out_data;
  logic                 busy;

  fir3_tdm_sched #(.NCH(NCH), .W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_we   (coef_we),
    .coef_sel  (coef_sel),
    .coef_data (coef_data),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Exact adder variant.
  assign add_s = add_a + add_b;

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  // Reference model state
  logic [W-1:0] m_coef [3];
  logic [W-1:0] m_h1 [NCH];
  logic [W-1:0] m_h2 [NCH];
  int           m_rr;
  int           m_busy_left;
  bit           gnt_seen [NCH];
  logic [NCH-1:0] exp_ready;
  int           gch;
  bit           found;
  logic [W-1:0] y;
  exp_t         e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic longint prod(input logic [W-1:0] a, input logic [W-1:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(c));
    return p >>> FRAC;
  endfunction

  function automatic logic [W-1:0] ref_fir(input logic [W-1:0] x, input logic [W-1:0] h1,
                                           input logic [W-1:0] h2, input logic [W-1:0] c0,
                                           input logic [W-1:0] c1, input logic [W-1:0] c2);
    longint s;
    s = prod(x, c0) + prod(h1, c1) + prod(h2, c2);
    return s[W-1:0];
  endfunction

  // Model: one sample occupies the datapath for 5 cycles; arbitration and coefficient
  // writes only happen when the model is free.
  always @(negedge clk) begin
    exp_ready = '0;
    if (rst) begin
      for (int i = 0; i < 3; i++) m_coef[i] = '0;
      for (int i = 0; i < NCH; i++) begin
        m_h1[i] = '0;
        m_h2[i] = '0;
        gnt_seen[i] = 1'b0;
      end
      m_rr = 0;
      m_busy_left = 0;
      sb.delete();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_add_a", 32'(add_a), 0);
      chk("rst_add_b", 32'(add_b), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_ch", 32'(out_ch), 0);
    end else begin
      chk("busy", 32'(busy), 32'(m_busy_left > 0));
      // Cycles 2 and 3 of a sample are the only ones that use the adder.
      if (m_busy_left != 3 && m_busy_left != 2) begin
        chk("adder_idle", {add_a, add_b}, 0);
      end
      if (m_busy_left > 0) begin
        m_busy_left--;
      end else begin
        if (coef_we && coef_sel != 2'd3) m_coef[coef_sel] = coef_data;
        found = 1'b0;
        gch = 0;
        for (int k = 0; k < NCH; k++) begin
          if (!found && in_valid[(m_rr + k) % NCH]) begin
            found = 1'b1;
            gch = (m_rr + k) % NCH;
          end
        end
        if (found) begin
          exp_ready[gch] = 1'b1;
          y = ref_fir(in_data[gch*W +: W], m_h1[gch], m_h2[gch], m_coef[0], m_coef[1],
                      m_coef[2]);
          e.ch = gch;
          e.data = y;
          e.cyc = cyc + 4;
          sb.push_back(e);
          m_h2[gch] = m_h1[gch];
          m_h1[gch] = in_data[gch*W +: W];
          m_rr = (gch + 1) % NCH;
          m_busy_left = 4;
          gnt_seen[gch] = 1'b1;
        end
      end
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missing_out_valid", 0, 1);
        void'(sb.pop_front());
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_ch", 32'(out_ch), 32'(e.ch));
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wcoef(input int sel, input logic [W-1:0] val);
    coef_we = 1'b1;
    coef_sel = 2'(sel);
    coef_data = val;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic send(input int c, input logic [W-1:0] val);
    bit ok;
    ok = 1'b0;
    in_data[c*W +: W] = val;
    in_valid[c] = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      if (gnt_seen[c]) begin
        gnt_seen[c] = 1'b0;
        ok = 1'b1;
      end
    end
    chk("grant_wait", 32'(ok), 1);
    in_valid[c] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic clear_flags();
    for (int c = 0; c < NCH; c++) gnt_seen[c] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    coef_we = 1'b0;
    coef_sel = '0;
    coef_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Impulse on channel 0
    wcoef(0, 16'h4000);
    wcoef(1, 16'h2000);
    wcoef(2, 16'h2000);
    send(0, 16'h4000);
    send(0, 16'h0000);
    send(0, 16'h0000);
    send(0, 16'h0000);
    drain();

    // Fairness with all channels requesting continuously, distinct DC levels
    for (int c = 0; c < NCH; c++) in_data[c*W +: W] = W'(16'h0400 * (c + 1));
    in_valid = '1;
    repeat (40) begin
      tick();
      clear_flags();
    end
    in_valid = '0;
    drain();

    // Wrap-around without saturation
    wcoef(0, 16'h7FFF);
    wcoef(1, 16'h7FFF);
    wcoef(2, 16'h7FFF);
    send(1, 16'h7FFF);
    send(1, 16'h7FFF);
    send(1, 16'h7FFF);
    drain();

    // Coefficient write while busy is dropped
    wcoef(0, 16'h1000);
    in_data[2*W +: W] = 16'h1234;
    in_valid[2] = 1'b1;
    tick();
    in_valid[2] = 1'b0;
    clear_flags();
    coef_we = 1'b1;
    coef_sel = 2'd0;
    coef_data = 16'h2000;
    tick();
    tick();
    coef_we = 1'b0;
    drain();
    send(2, 16'h1234);
    wcoef(3, 16'h5555);
    wcoef(0, 16'h2000);
    send(2, 16'h1234);
    drain();

    // Write in the same IDLE cycle as a grant
    coef_we = 1'b1;
    coef_sel = 2'd1;
    coef_data = 16'h0800;
    in_data[3*W +: W] = 16'h3000;
    in_valid[3] = 1'b1;
    tick();
    coef_we = 1'b0;
    in_valid[3] = 1'b0;
    clear_flags();
    drain();
    send(3, 16'hC000);
    drain();

    // Randomised traffic and coefficient writes
    repeat (500) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (gnt_seen[c]) begin
          gnt_seen[c] = 1'b0;
          in_valid[c] = 1'b0;
        end
        if (!in_valid[c] && $urandom_range(0, 3) == 0) begin
          in_valid[c] = 1'b1;
          in_data[c*W +: W] = W'($urandom);
        end
      end
      coef_we = ($urandom_range(0, 15) == 0);
      coef_sel = 2'($urandom_range(0, 3));
      coef_data = W'($urandom);
    end
    in_valid = '0;
    coef_we = 1'b0;
    tick();
    clear_flags();
    drain();

    // Reset during TAP2 aborts the sample and clears histories
    in_data[0 +: W] = 16'h4000;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    clear_flags();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    wcoef(0, 16'h4000);
    wcoef(1, 16'h2000);
    send(0, 16'h4000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
